// File: rtl/hci_pkg.sv
// Shared types and default timing for the button debounce bank.
//   hold_state_t : per-channel auto-repeat hold state
//   DEF_*        : default parameter values, expressed in clk cycles
package hci_pkg;

    typedef enum logic [1:0] {
        H_IDLE   = 2'd0,
        H_DELAY  = 2'd1,
        H_REPEAT = 2'd2
    } hold_state_t;

    localparam int unsigned DEF_NUM_CH          = 5;
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
    localparam int unsigned DEF_REPEAT_DELAY    = 50000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: input synchroniser, mismatch-count debouncer, hold FSM.
//   clk, reset_   : clock, synchronous active-low reset
//   btn_in        : raw asynchronous pin (1 = pressed)
//   repeat_en     : auto-repeat enable
//   btn_level     : debounced level
//   btn_press     : pulse in the first cycle btn_level reads 1
//   btn_release   : pulse in the first cycle btn_level reads 0
//   btn_repeat    : auto-repeat pulse while held
module debounce_channel
    import hci_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset_,
    input  logic btn_in,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    // Debounce counter tops out at DEBOUNCE_CYCLES-1; the next mismatch toggles.
    localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    logic [SYNC_STAGES-1:0] sync_q,     sync_d;
    logic [DB_W-1:0]        db_cnt_q,   db_cnt_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    hold_state_t            state_q,    state_d;
    logic                   level_q,    level_d;
    logic                   press_q,    press_d;
    logic                   release_q,  release_d;
    logic                   repeat_q,   repeat_d;
    logic                   sync_in;

    assign sync_in = sync_q[SYNC_STAGES-1];

    // Next-state: synchroniser shift, debounce counter, hold FSM.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], btn_in};
        db_cnt_d   = '0;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        repeat_d   = 1'b0;

        if (sync_in != level_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d   = sync_in;
                press_d   = sync_in;
                release_d = ~sync_in;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        // Looking at the next level lets a release pre-empt a same-cycle repeat.
        if (!level_d || !repeat_en) begin
            state_d    = H_IDLE;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                H_IDLE: begin
                    if (press_d) begin
                        state_d    = H_DELAY;
                        hold_cnt_d = '0;
                    end
                end
                H_DELAY: begin
                    if (hold_cnt_q == HOLD_W'(REPEAT_DELAY - 1)) begin
                        state_d    = H_REPEAT;
                        hold_cnt_d = '0;
                        repeat_d   = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                H_REPEAT: begin
                    if (hold_cnt_q == HOLD_W'(REPEAT_PERIOD - 1)) begin
                        hold_cnt_d = '0;
                        repeat_d   = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_d    = H_IDLE;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    // All channel state, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            sync_q     <= '0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            state_q    <= H_IDLE;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            state_q    <= state_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            repeat_q   <= repeat_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;

endmodule

// File: rtl/button_debounce_bank.sv
// Bank of NUM_CH independent debounced buttons with auto-repeat.
//   clk, reset_   : clock, synchronous active-low reset
//   btn_in        : raw button pins, 1 = pressed
//   repeat_en     : per-channel auto-repeat enable
//   btn_level     : debounced levels
//   btn_press     : one-cycle accepted-press pulses
//   btn_release   : one-cycle accepted-release pulses
//   btn_repeat    : one-cycle auto-repeat pulses
module button_debounce_bank
    import hci_pkg::*;
#(
    parameter int unsigned NUM_CH          = DEF_NUM_CH,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic [NUM_CH-1:0] btn_in,
    input  logic [NUM_CH-1:0] repeat_en,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] btn_press,
    output logic [NUM_CH-1:0] btn_release,
    output logic [NUM_CH-1:0] btn_repeat
);

    // One self-contained channel per button.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .reset_      (reset_),
            .btn_in      (btn_in[i]),
            .repeat_en   (repeat_en[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_repeat  (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_debounce_bank.sv
// Self-checking bench for button_debounce_bank: behavioural model compared
// every cycle, directed scenarios with literal expectations, random phase.
module tb_button_debounce_bank;

    localparam int unsigned NUM_CH = 5;
    localparam int unsigned SYNC   = 2;
    localparam int unsigned DB     = 4;
    localparam int unsigned RD     = 10;
    localparam int unsigned RP     = 3;

    logic              clk = 1'b0;
    logic              reset_ = 1'b0;
    logic [NUM_CH-1:0] btn_in = '0;
    logic [NUM_CH-1:0] repeat_en = '0;
    logic [NUM_CH-1:0] btn_level, btn_press, btn_release, btn_repeat;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int base = 0;
    bit started = 1'b0;

    button_debounce_bank #(
        .NUM_CH          (NUM_CH),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .reset_      (reset_),
        .btn_in      (btn_in),
        .repeat_en   (repeat_en),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit [NUM_CH-1:0] m_level = '0, m_press = '0, m_release = '0, m_repeat = '0;
    bit              syncq[NUM_CH][$];
    bit              win[NUM_CH][$];
    bit              armed[NUM_CH];
    int              press_t[NUM_CH];

    always @(posedge clk) begin
        cyc++;
        if (!reset_) begin
            started   = 1'b1;
            m_level   = '0;
            m_press   = '0;
            m_release = '0;
            m_repeat  = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                syncq[ch].delete();
                for (int s = 0; s < SYNC; s++) syncq[ch].push_back(1'b0);
                win[ch].delete();
                armed[ch] = 1'b0;
            end
        end else begin
            m_press   = '0;
            m_release = '0;
            m_repeat  = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                bit sv;
                bit all_diff;
                // Raw pin appears at the debouncer SYNC edges later.
                syncq[ch].push_back(btn_in[ch]);
                sv = syncq[ch].pop_front();
                win[ch].push_back(sv);
                if (win[ch].size() > DB) void'(win[ch].pop_front());
                // Accept when the last DB synchronised samples all disagree.
                all_diff = (win[ch].size() == DB);
                foreach (win[ch][k]) if (win[ch][k] == m_level[ch]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[ch]   = ~m_level[ch];
                    m_press[ch]   = m_level[ch];
                    m_release[ch] = ~m_level[ch];
                end
                // Repeats at press+RD, press+RD+RP, ... while held and enabled.
                if (m_press[ch] && repeat_en[ch]) begin
                    armed[ch]   = 1'b1;
                    press_t[ch] = cyc;
                end else if (!m_level[ch] || !repeat_en[ch]) begin
                    armed[ch] = 1'b0;
                end else if (armed[ch] && (cyc - press_t[ch]) >= int'(RD)
                             && ((cyc - press_t[ch] - int'(RD)) % int'(RP)) == 0) begin
                    m_repeat[ch] = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("model_level",   btn_level,   m_level);
            chk("model_press",   btn_press,   m_press);
            chk("model_release", btn_release, m_release);
            chk("model_repeat",  btn_repeat,  m_repeat);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_seq();
        @(negedge clk);
        base = cyc;
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < base + k) @(negedge clk);
    endtask

    task automatic settle(input int n);
        btn_in = '0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rep;
        int first_rep;
        int last_rep;
        int rel_cyc;
        int rep_at_rel;

        // Reset with all buttons held.
        reset_    = 1'b0;
        btn_in    = '1;
        repeat_en = '0;
        repeat (3) @(negedge clk);
        chk("rst_level",   btn_level,   '0);
        chk("rst_press",   btn_press,   '0);
        chk("rst_release", btn_release, '0);
        chk("rst_repeat",  btn_repeat,  '0);
        start_seq();
        reset_ = 1'b1;
        wait_cyc(1); chk("post_rst_press", btn_press, '0);
        wait_cyc(5); chk("held_rst_lvl5", btn_level, '0);
        wait_cyc(6); chk("held_rst_press6", btn_press, 5'b11111);
        wait_cyc(7); chk("held_rst_press7", btn_press, '0);
        settle(15);

        // Clean press and release on ch0.
        start_seq();
        btn_in[0] = 1'b1;
        wait_cyc(5);  chk("ch0_lvl5",   btn_level, '0);
        wait_cyc(6);  chk("ch0_press6", btn_press, 5'b00001);
                      chk("ch0_lvl6",   btn_level, 5'b00001);
        wait_cyc(7);  chk("ch0_press7", btn_press, '0);
        wait_cyc(20); btn_in[0] = 1'b0;
        wait_cyc(25); chk("ch0_rel25",  btn_release, '0);
        wait_cyc(26); chk("ch0_rel26",  btn_release, 5'b00001);
                      chk("ch0_lvl26",  btn_level, '0);
        settle(10);

        // 3-cycle glitch on ch1.
        start_seq();
        btn_in[1] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            wait_cyc(k);
            if (k == 3) btn_in[1] = 1'b0;
            chk("ch1_glitch", NUM_CH'({btn_level[1], btn_press[1], btn_release[1]}), '0);
        end
        settle(10);

        // Auto-repeat on ch2, held cycles 0..39.
        n_rep = 0; first_rep = -1; last_rep = -1; rel_cyc = -1; rep_at_rel = 0;
        start_seq();
        repeat_en[2] = 1'b1;
        btn_in[2]    = 1'b1;
        for (int k = 0; k <= 52; k++) begin
            wait_cyc(k);
            if (k == 40) btn_in[2] = 1'b0;
            if (btn_repeat[2]) begin
                n_rep++;
                if (first_rep < 0) first_rep = k;
                last_rep = k;
            end
            if (btn_release[2]) begin
                rel_cyc    = k;
                rep_at_rel = int'(btn_repeat[2]);
            end
        end
        chk_int("rep_count", n_rep, 10);
        chk_int("rep_first", first_rep, 16);
        chk_int("rep_last",  last_rep, 43);
        chk_int("rep_release_cyc", rel_cyc, 46);
        chk_int("rep_at_release", rep_at_rel, 0);
        repeat_en = '0;
        settle(10);

        // Enabling repeat after the press must not start repeat.
        n_rep = 0;
        start_seq();
        btn_in[2] = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            wait_cyc(k);
            if (k == 8) repeat_en[2] = 1'b1;
            if (btn_repeat[2]) n_rep++;
        end
        chk_int("late_en_repeats", n_rep, 0);
        repeat_en = '0;
        settle(12);

        // Simultaneous press on ch0 and ch4.
        start_seq();
        btn_in = 5'b10001;
        wait_cyc(6); chk("dual_press6", btn_press, 5'b10001);
        wait_cyc(7); chk("dual_press7", btn_press, '0);
        settle(12);

        // Reset mid-hold on ch3.
        start_seq();
        btn_in[3] = 1'b1;
        wait_cyc(6);  chk("ch3_press6", btn_press, 5'b01000);
        wait_cyc(10); reset_ = 1'b0;
        wait_cyc(11); chk("ch3_rst_lvl", btn_level, '0);
                      chk("ch3_rst_rel", btn_release, '0);
                      reset_ = 1'b1;
        for (int k = 12; k <= 20; k++) begin
            wait_cyc(k);
            chk("ch3_no_rel", btn_release, '0);
            if (k == 16) chk("ch3_press16", btn_press, '0);
            if (k == 17) chk("ch3_press17", btn_press, 5'b01000);
        end
        settle(12);

        // Random phase, model-checked each cycle.
        repeat_en = '1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!reset_) reset_ = 1'b1;
            else if ($urandom_range(0, 399) == 0) reset_ = 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++)
                if ($urandom_range(0, (n < 1500) ? 11 : 29) == 0) btn_in[ch] = ~btn_in[ch];
            if ($urandom_range(0, 99) == 0) repeat_en = NUM_CH'($urandom) | NUM_CH'($urandom);
        end
        reset_ = 1'b1;
        settle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_debounce_bank.md
BUTTON_DEBOUNCE_BANK -- requirements
Module: button_debounce_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 5: number of independent button channels.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, at least 2.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 250000: consecutive stable cycles required to accept a change, at least 2.
REQ-004 SHALL have parameter REPEAT_DELAY, default 50000000: cycles from press acceptance to the first auto-repeat pulse.
REQ-005 SHALL have parameter REPEAT_PERIOD, default 10000000: cycles between subsequent auto-repeat pulses.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is in this domain.
REQ-007 SHALL have port reset_, input, 1 bit: reset is synchronous and active-low.
REQ-008 SHALL have port btn_in, input, NUM_CH bits: raw asynchronous button pins, 1 = pressed.
REQ-009 SHALL have port repeat_en, input, NUM_CH bits: per-channel auto-repeat enable.
REQ-010 SHALL have port btn_level, output, NUM_CH bits: debounced level.
REQ-011 SHALL have port btn_press, output, NUM_CH bits: one-cycle pulse on an accepted press.
REQ-012 SHALL have port btn_release, output, NUM_CH bits: one-cycle pulse on an accepted release.
REQ-013 SHALL have port btn_repeat, output, NUM_CH bits: one-cycle auto-repeat pulse while held.

Function
REQ-014 Each channel SHALL pass btn_in through SYNC_STAGES flops before any other use.
REQ-015 Mismatch counter: increments each cycle the synchronised input differs from btn_level, and clears to 0 on any equal cycle.
REQ-016 When the counter reaches DEBOUNCE_CYCLES, btn_level SHALL toggle on that edge and the counter SHALL clear.
REQ-017 End-to-end latency from a clean btn_in edge to btn_level SHALL be SYNC_STAGES+DEBOUNCE_CYCLES cycles.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES synchronised cycles SHALL produce no output change.
REQ-019 btn_press/btn_release SHALL be high in exactly the first cycle btn_level reads 1/0 after a toggle.
REQ-020 Per-channel hold FSM states: H_IDLE, H_DELAY, H_REPEAT.
REQ-021 H_IDLE->H_DELAY on an accepted press when repeat_en=1; the hold counter clears.
REQ-022 H_DELAY->H_REPEAT after REPEAT_DELAY cycles, pulsing btn_repeat; thereafter a pulse is emitted every REPEAT_PERIOD cycles.
REQ-023 Any state->H_IDLE on btn_level=0 or repeat_en=0; no btn_repeat in that cycle.
REQ-024 When an accepted release and a repeat deadline fall in the same cycle, release SHALL win: btn_release=1, btn_repeat=0.
REQ-025 btn_press never coincides with btn_repeat; a press arriving while repeat_en=0 stays in H_IDLE, and enabling repeat_en later does not start repeat until the next press.
REQ-026 Channels SHALL be fully independent; simultaneous events on any subset are all reported in the same cycle.
REQ-027 Counter widths SHALL be $clog2(max value+1); counters saturate or clear, and never wrap.

Reset
REQ-028 On reset_=0 at a clk edge, all synchroniser flops, counters and btn_level SHALL be 0, and the FSM SHALL be H_IDLE.
REQ-029 btn_press, btn_release and btn_repeat SHALL be 0 during and in the first cycle after reset.
REQ-030 Reset mid-hold SHALL emit no btn_release; a button still held afterwards yields a fresh btn_press after full latency.

Structure
REQ-031 Package hci_pkg SHALL hold the hold_state_t enum and the default timing constants.
REQ-032 Sub-module debounce_channel (one channel: sync, debounce, hold FSM) SHALL be instantiated NUM_CH times via generate.

Verification (NUM_CH=5, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3; cycle 0 = input change)
REQ-033 Clean press on ch0 -> btn_level[0] rises and btn_press[0]=1 at cycle 6 only; release 20 cycles later -> btn_release[0] at cycle 26.
REQ-034 3-cycle high glitch on ch1 -> btn_level, btn_press and btn_release for ch1 stay 0 throughout.
REQ-035 repeat_en[2]=1, ch2 held cycles 0-39 -> press at 6; repeats at 16,19,...,43 (10 pulses); release at 46 with no repeat at 46.
REQ-036 ch0 and ch4 pressed the same cycle -> both btn_press bits high together at cycle 6; other channels remain quiet.
REQ-037 ch3 held and accepted, reset_=0 for 1 cycle -> all outputs 0 with no btn_release; btn_press[3] again 6 cycles after reset release.
REQ-038 btn_in all high through reset -> btn_press=5'b11111 exactly once, SYNC_STAGES+DEBOUNCE_CYCLES cycles after reset_ rises.
